// File: rtl/nf_i_exu_md_pkg.sv
// Shared execute-stage definitions: ALU one-hot bit positions, md_op codes, md FSM states.
// Latency: none (declarations and pure helper functions only).
// Backpressure: not applicable.
package nf_i_exu_md_pkg;

    // Bit positions inside the 32-bit one-hot ALU_Code
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLL  = 2;
    localparam int ALU_SRL  = 3;
    localparam int ALU_SRA  = 4;
    localparam int ALU_AND  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLT  = 8;
    localparam int ALU_SLTU = 9;
    localparam int ALU_LUI  = 10;

    // Multiply/divide operation codes; bit 2 set means divide/remainder
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    // Iterative md engine states
    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // Remainder ops take the sign of the dividend rather than the quotient sign
    function automatic logic md_is_rem(input logic [2:0] op);
        return (op[2:1] == 2'b11);
    endfunction

    // Operand A is signed for MUL, MULH, MULHSU, DIV, REM
    function automatic logic md_a_signed(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    endfunction

    // Operand B is signed for MUL, MULH, DIV, REM
    function automatic logic md_b_signed(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    endfunction

endpackage

// File: rtl/nf_alu.sv
// Integer ALU selected by a one-hot operation code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result follows inputs every cycle.
module nf_alu
    import nf_i_exu_md_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic [SHW-1:0]  shamt_i,
    input  logic [31:0]     alu_code_i,
    output logic [XLEN-1:0] result_o
);

    logic lt_s;
    logic lt_u;

    assign lt_s = ($signed(src_a_i) < $signed(src_b_i));
    assign lt_u = (src_a_i < src_b_i);

    // One-hot OR-mux of every operation; an all-zero code yields zero
    always_comb begin
        result_o = '0;
        if (alu_code_i[ALU_ADD])  result_o |= src_a_i + src_b_i;
        if (alu_code_i[ALU_SUB])  result_o |= src_a_i - src_b_i;
        if (alu_code_i[ALU_SLL])  result_o |= src_a_i << shamt_i;
        if (alu_code_i[ALU_SRL])  result_o |= src_a_i >> shamt_i;
        if (alu_code_i[ALU_SRA])  result_o |= $signed(src_a_i) >>> shamt_i;
        if (alu_code_i[ALU_AND])  result_o |= src_a_i & src_b_i;
        if (alu_code_i[ALU_OR])   result_o |= src_a_i | src_b_i;
        if (alu_code_i[ALU_XOR])  result_o |= src_a_i ^ src_b_i;
        if (alu_code_i[ALU_SLT])  result_o |= {{(XLEN-1){1'b0}}, lt_s};
        if (alu_code_i[ALU_SLTU]) result_o |= {{(XLEN-1){1'b0}}, lt_u};
        if (alu_code_i[ALU_LUI])  result_o |= src_b_i;
    end

endmodule

// File: rtl/nf_md_unit.sv
// Iterative multiply/divide engine: shift-add multiply, restoring divide on magnitudes.
// Latency: XLEN+1 cycles from accept to result_vld_o, 1 cycle for divide by zero.
// Backpressure: busy_o stalls the pipeline while accepting and calculating; inputs ignored once accepted.
module nf_md_unit
    import nf_i_exu_md_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            md_req_i,
    input  logic [2:0]      md_op_i,
    input  logic [XLEN-1:0] rd1_i,
    input  logic [XLEN-1:0] rd2_i,
    output logic            busy_o,
    output logic            result_vld_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned LAST = XLEN - 1;

    logic [1:0]      state_q, state_d;
    logic [SHW:0]    cnt_q,   cnt_d;
    md_op_e          op_q,    op_d;
    logic [XLEN-1:0] b_q,     b_d;     // multiplicand / divisor magnitude
    logic [XLEN-1:0] hi_q,    hi_d;    // product high half / partial remainder
    logic [XLEN-1:0] lo_q,    lo_d;    // multiplier then product low half / quotient
    logic            neg_q,   neg_d;   // negate the final result

    logic            a_neg, b_neg, div0;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] div_diff;
    logic            div_ok;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] md_res;

    assign a_neg = md_a_signed(md_op_i) & rd1_i[XLEN-1];
    assign b_neg = md_b_signed(md_op_i) & rd2_i[XLEN-1];
    assign a_mag = a_neg ? -rd1_i : rd1_i;
    assign b_mag = b_neg ? -rd2_i : rd2_i;
    assign div0  = md_is_div(md_op_i) && (rd2_i == '0);

    // One multiply step: conditionally add multiplicand, then shift {carry,hi,lo} right
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // One divide step: shift next dividend bit into the remainder and trial-subtract
    assign rem_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_diff = {1'b0, rem_sh} - {2'b00, b_q};
    assign div_ok   = ~div_diff[XLEN+1];

    // Next-state logic for FSM, counter and accumulators
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        case (state_q)
            MD_IDLE: begin
                if (md_req_i) begin
                    op_d  = md_op_e'(md_op_i);
                    cnt_d = '0;
                    if (div0) begin
                        // Quotient all ones, remainder is the raw dividend
                        state_d = MD_DONE;
                        b_d     = '0;
                        hi_d    = rd1_i;
                        lo_d    = '1;
                        neg_d   = 1'b0;
                    end else begin
                        state_d = MD_CALC;
                        b_d     = b_mag;
                        hi_d    = '0;
                        lo_d    = a_mag;
                        neg_d   = md_is_rem(md_op_i) ? a_neg : (a_neg ^ b_neg);
                    end
                end
            end
            MD_CALC: begin
                if (md_is_div(op_q)) begin
                    hi_d = div_ok ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], div_ok};
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST[SHW:0]) begin
                    state_d = MD_DONE;
                    cnt_d   = '0;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MUL;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
        end
    end

    assign prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

    // Sign fix-up and selection of the final md result
    always_comb begin
        md_res = '0;
        case (op_q)
            MD_MUL:                       md_res = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: md_res = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              md_res = neg_q ? -lo_q : lo_q;
            default:                      md_res = neg_q ? -hi_q : hi_q;
        endcase
    end

    assign busy_o       = ((state_q == MD_IDLE) && md_req_i) || (state_q == MD_CALC);
    assign result_vld_o = (state_q == MD_DONE);
    assign result_o     = result_vld_o ? md_res : '0;

endmodule

// File: rtl/nf_i_exu_md.sv
// Execute unit: combinational ALU plus iterative multiply/divide, sharing one result port.
// Latency: ALU zero cycles; md XLEN+1 cycles (1 for divide by zero).
// Backpressure: busy requests a pipeline stall while an md op is accepted or calculating.
module nf_i_exu_md
    import nf_i_exu_md_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic [XLEN-1:0] ext_data,
    input  logic            srcB_sel,
    input  logic [SHW-1:0]  shamt,
    input  logic [31:0]     ALU_Code,
    input  logic            md_req,
    input  logic [2:0]      md_op,
    output logic            busy,
    output logic            result_vld,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] md_res;
    logic            md_vld;

    assign src_b = srcB_sel ? rd2 : ext_data;

    nf_alu #(.XLEN(XLEN), .SHW(SHW)) u_alu (
        .src_a_i    (rd1),
        .src_b_i    (src_b),
        .shamt_i    (shamt),
        .alu_code_i (ALU_Code),
        .result_o   (alu_res)
    );

    nf_md_unit #(.XLEN(XLEN), .SHW(SHW)) u_md (
        .clk_i        (clk),
        .rst_i        (rst),
        .md_req_i     (md_req),
        .md_op_i      (md_op),
        .rd1_i        (rd1),
        .rd2_i        (rd2),
        .busy_o       (busy),
        .result_vld_o (md_vld),
        .result_o     (md_res)
    );

    // md result wins only during its single valid cycle
    assign result_vld = md_vld;
    assign result     = md_vld ? md_res : alu_res;

endmodule

// File: tb/tb_nf_i_exu_md.sv
// Self-checking bench for nf_i_exu_md at XLEN=32 against a behavioural reference model.
// Latency checked as edges counted from the accepting edge (inclusive) to result_vld.
// Backpressure: checks busy before accept, during calculation and in the result cycle.
module tb_nf_i_exu_md;
    import nf_i_exu_md_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd1, rd2, ext_data, ALU_Code;
    logic        srcB_sel;
    logic [4:0]  shamt;
    logic        md_req;
    logic [2:0]  md_op;
    logic        busy, result_vld;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    nf_i_exu_md #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .rd1(rd1), .rd2(rd2), .ext_data(ext_data),
        .srcB_sel(srcB_sel), .shamt(shamt), .ALU_Code(ALU_Code),
        .md_req(md_req), .md_op(md_op), .busy(busy),
        .result_vld(result_vld), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] alu_ref(input int idx, input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh);
        case (idx)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $signed(a) >>> sh;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return b;
        endcase
    endfunction

    // Full-width arithmetic reference for every md op
    function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        int si, sj;
        sa = {{32{a[31]}}, a};
        ua = {32'd0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        si = a;
        sj = b;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return si / sj;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return si % sj;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drive one md request (called #1 after an edge) and measure it; operands are scrambled during CALC
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic busy_pre,
                          output logic busy_calc_bad, output logic busy_done);
        md_req = 1'b1; md_op = op; rd1 = a; rd2 = b;
        lat = 0; res = 'x; busy_calc_bad = 1'b0; busy_done = 1'bx;
        #1 busy_pre = busy;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (result_vld === 1'b1) begin
                res = result;
                busy_done = busy;
                break;
            end
            if (busy !== 1'b1) busy_calc_bad = 1'b1;
            rd1 = $urandom; rd2 = $urandom; md_op = 3'($urandom_range(0, 7));
            md_req = 1'($urandom_range(0, 1));
        end
        md_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; md_req = 1'b0; md_op = 3'd0; rd1 = 32'd9; rd2 = 32'd4; ext_data = 32'd1;
        srcB_sel = 1'b1; shamt = 5'd0; ALU_Code = 32'd1 << ALU_SUB;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (result_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", result_vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (result !== 32'd5) begin errors++; $display("FAIL reset_alu: got %h want 5", result); end
        md_req = 1'b1; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_req: got %b want 1", busy); end
        md_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu;
        logic [31:0] exp;
        int idx;
        md_req = 1'b0; ALU_Code = 32'd1 << ALU_ADD; rd1 = 32'd5; ext_data = 32'd7; srcB_sel = 1'b0; rd2 = $urandom;
        #1;
        checks++; if (result !== 32'd12) begin errors++; $display("FAIL alu_add_directed: got %h want 0000000c", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alu_add_busy: got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, 10);
            ALU_Code = 32'd1 << idx;
            rd1 = $urandom; rd2 = $urandom; ext_data = $urandom;
            srcB_sel = 1'($urandom_range(0, 1)); shamt = 5'($urandom);
            exp = alu_ref(idx, rd1, srcB_sel ? rd2 : ext_data, shamt);
            #1;
            checks++;
            if (result !== exp) begin errors++; $display("FAIL alu_op%0d: got %h want %h", idx, result, exp); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_md_directed;
        logic [2:0]  ops [10] = '{MD_MUL, MD_MULHU, MD_MULH, MD_DIV, MD_REM, MD_DIV, MD_REM, MD_DIVU, MD_REMU, MD_MULHSU};
        logic [31:0] as  [10] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                                  32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'hFFFFFFFF};
        logic [31:0] bs  [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic [31:0] exps[10] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'h80000000, 32'h0,
                                  32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFFF};
        int          lats[10] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 33};
        int lat; logic [31:0] res; logic bp, bcb, bd;
        for (int i = 0; i < 10; i++) begin
            run_md(ops[i], as[i], bs[i], lat, res, bp, bcb, bd);
            checks++; if (res !== exps[i]) begin errors++; $display("FAIL md_dir%0d_result: got %h want %h", i, res, exps[i]); end
            checks++; if (lat != lats[i]) begin errors++; $display("FAIL md_dir%0d_latency: got %0d want %0d", i, lat, lats[i]); end
            checks++; if (bd !== 1'b0) begin errors++; $display("FAIL md_dir%0d_busy_done: got %b want 0", i, bd); end
            checks++; if (bp !== 1'b1) begin errors++; $display("FAIL md_dir%0d_busy_accept: got %b want 1", i, bp); end
            checks++; if (bcb !== 1'b0) begin errors++; $display("FAIL md_dir%0d_busy_calc: dropped, want 1", i); end
        end
    endtask

    task automatic test_md_random;
        int lat, explat; logic [31:0] res, a, b, exp; logic [2:0] op; logic bp, bcb, bd;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 17));
            exp = md_ref(op, a, b);
            explat = (op[2] && b == 0) ? 1 : 33;
            run_md(op, a, b, lat, res, bp, bcb, bd);
            checks++; if (res !== exp) begin errors++; $display("FAIL md_rand op%0d %h,%h: got %h want %h", op, a, b, res, exp); end
            checks++; if (lat != explat) begin errors++; $display("FAIL md_rand_latency op%0d: got %0d want %0d", op, lat, explat); end
            checks++; if (bcb !== 1'b0) begin errors++; $display("FAIL md_rand_busy_calc op%0d: dropped, want 1", op); end
        end
    endtask

    task automatic test_reset_abort;
        int lat; logic [31:0] res; logic bp, bcb, bd; logic saw;
        md_req = 1'b1; md_op = MD_MUL; rd1 = 32'd123; rd2 = 32'd456;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1; md_req = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (result_vld !== 1'b0) begin errors++; $display("FAIL abort_vld: got %b want 0", result_vld); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (result_vld !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_quiet: got activity, want none"); end
        run_md(MD_MUL, 32'd3, 32'd4, lat, res, bp, bcb, bd);
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL abort_next_result: got %h want 0000000c", res); end
        checks++; if (lat != 33) begin errors++; $display("FAIL abort_next_latency: got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back;
        int lat;
        md_req = 1'b1; md_op = MD_MUL; rd1 = 32'd6; rd2 = 32'd7;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1; lat++;
            if (result_vld === 1'b1) break;
        end
        checks++; if (result !== 32'd42) begin errors++; $display("FAIL b2b_first: got %h want 0000002a", result); end
        md_op = MD_DIVU; rd1 = 32'd100; rd2 = 32'd7;
        #1;
        checks++; if (result !== 32'd42) begin errors++; $display("FAIL b2b_done_hold: got %h want 0000002a", result); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || result_vld !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got busy=%b vld=%b want busy=1 vld=0", busy, result_vld);
        end
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1; lat++;
            if (result_vld === 1'b1) break;
        end
        checks++; if (result !== 32'd14) begin errors++; $display("FAIL b2b_second: got %h want 0000000e", result); end
        checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        md_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (result_vld !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_release: got busy=%b vld=%b want 0 0", busy, result_vld);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_md_directed();
        test_md_random();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
